// File: rtl/ofdm_qam_mapper_if.sv
// Point stream bundle between the preamble ROM, the QAM mapper and the IFFT stage.
// The mapper takes the slave view; the environment driving it takes the master view.
interface ofdm_qam_mapper_if #(
  parameter int OUT_WIDTH = 16,
  parameter int SC_W      = 6
);
  logic [3:0]                  idata;
  logic                        valid_rom;
  logic                        ready_out;
  logic                        ready_in;
  logic                        valid_out;
  logic signed [OUT_WIDTH-1:0] i_out;
  logic signed [OUT_WIDTH-1:0] q_out;
  logic [SC_W-1:0]             sc_idx;
  logic                        sof;
  logic                        eof;

  modport master (
    output idata, valid_rom, ready_in,
    input  ready_out, valid_out, i_out, q_out, sc_idx, sof, eof
  );

  modport slave (
    input  idata, valid_rom, ready_in,
    output ready_out, valid_out, i_out, q_out, sc_idx, sof, eof
  );
endinterface

// File: rtl/ofdm_qam_mapper.sv
// QPSK / Gray 16-QAM mapper with a one-register map stage, small output FIFO
// and subcarrier framing (sc_idx, sof, eof) for the IFFT stage.
module ofdm_qam_mapper #(
  parameter int OUT_WIDTH  = 16,
  parameter int QPSK_AMP   = 11585,
  parameter int QAM_UNIT   = 5181,
  parameter int FIFO_DEPTH = 4,
  parameter int N_SC       = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mod_switch,
  output logic                overflow,
  ofdm_qam_mapper_if.slave    bus
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 2;
  localparam int SC_W = $clog2(N_SC);

  localparam logic signed [OUT_WIDTH-1:0] L_QPSK = OUT_WIDTH'(QPSK_AMP);
  localparam logic signed [OUT_WIDTH-1:0] L_U    = OUT_WIDTH'(QAM_UNIT);
  localparam logic signed [OUT_WIDTH-1:0] L_3U   = OUT_WIDTH'(3 * QAM_UNIT);

  logic                        r_mode;
  logic                        r_map_valid;
  logic signed [OUT_WIDTH-1:0] r_map_i;
  logic signed [OUT_WIDTH-1:0] r_map_q;
  logic signed [OUT_WIDTH-1:0] r_fifo_i [FIFO_DEPTH];
  logic signed [OUT_WIDTH-1:0] r_fifo_q [FIFO_DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic [SC_W-1:0]             r_sc_idx;
  logic                        r_overflow;

  logic                        w_valid_out;
  logic                        w_pop;
  logic                        w_accept;
  logic [CW-1:0]               w_occ;
  logic [CW-1:0]               w_commit;
  logic signed [OUT_WIDTH-1:0] w_map_i;
  logic signed [OUT_WIDTH-1:0] w_map_q;

  function automatic logic signed [OUT_WIDTH-1:0] gray_level(input logic [1:0] g);
    case (g)
      2'b00:   return -L_3U;
      2'b01:   return -L_U;
      2'b11:   return L_U;
      default: return L_3U;
    endcase
  endfunction

  always_comb begin
    w_map_i = '0;
    w_map_q = '0;
    if (r_mode) begin
      w_map_i = gray_level(bus.idata[3:2]);
      w_map_q = gray_level(bus.idata[1:0]);
    end else begin
      w_map_i = bus.idata[1] ? -L_QPSK : L_QPSK;
      w_map_q = bus.idata[0] ? -L_QPSK : L_QPSK;
    end
  end

  assign w_valid_out = (r_count != '0);
  assign w_pop       = w_valid_out && bus.ready_in;
  assign w_occ       = r_count + CW'(r_map_valid) + CW'(bus.valid_rom);
  // A word is taken only if the FIFO level committed at this edge leaves room
  // for it when it leaves the map register next cycle.
  assign w_commit    = r_count + CW'(r_map_valid) - CW'(w_pop);
  assign w_accept    = !reset && bus.valid_rom && (w_commit < CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= mod_switch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_map_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_sc_idx    <= '0;
    end else begin
      r_map_valid <= w_accept;
      if (bus.valid_rom && !w_accept) begin
        r_overflow <= 1'b1;
      end
      if (r_map_valid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_sc_idx <= (r_sc_idx == SC_W'(N_SC - 1)) ? '0 : r_sc_idx + 1'b1;
      end
      r_count <= r_count + CW'(r_map_valid) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_map_i <= w_map_i;
      r_map_q <= w_map_q;
    end
    if (!reset && r_map_valid) begin
      r_fifo_i[r_wr_ptr] <= r_map_i;
      r_fifo_q[r_wr_ptr] <= r_map_q;
    end
  end

  assign bus.ready_out = !reset && (w_occ < CW'(FIFO_DEPTH));
  assign bus.valid_out = w_valid_out;
  assign bus.i_out     = w_valid_out ? r_fifo_i[r_rd_ptr] : '0;
  assign bus.q_out     = w_valid_out ? r_fifo_q[r_rd_ptr] : '0;
  assign bus.sc_idx    = r_sc_idx;
  assign bus.sof       = w_valid_out && (r_sc_idx == '0);
  assign bus.eof       = w_valid_out && (r_sc_idx == SC_W'(N_SC - 1));
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_ofdm_qam_mapper.sv
// Directed bench for ofdm_qam_mapper: mapping table, latency, back-pressure,
// overflow, framing under random stalls and reset mid-stream.
module tb_ofdm_qam_mapper;

  logic clk = 1'b0;
  logic reset;
  logic mod_switch;
  logic overflow;

  ofdm_qam_mapper_if #(.OUT_WIDTH(16), .SC_W(6)) bus ();

  ofdm_qam_mapper #(
    .OUT_WIDTH (16),
    .QPSK_AMP  (11585),
    .QAM_UNIT  (5181),
    .FIFO_DEPTH(4),
    .N_SC      (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mod_switch(mod_switch),
    .overflow  (overflow),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  localparam int A  = 11585;
  localparam int U  = 5181;
  localparam int U3 = 15543;

  typedef struct {
    logic       mode;
    logic [3:0] idata;
    int         exp_i;
    int         exp_q;
  } vec_t;

  vec_t vecs [22];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m, input bit check_vals);
    reset         = 1'b1;
    mod_switch    = m;
    bus.valid_rom = 1'b0;
    bus.idata     = 4'h0;
    bus.ready_in  = 1'b0;
    tick();
    @(negedge clk);
    if (check_vals) begin
      chk("rst_valid_out", bus.valid_out, 0);
      chk("rst_ready_out", bus.ready_out, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_sc_idx", bus.sc_idx, 0);
      chk("rst_sof", bus.sof, 0);
      chk("rst_eof", bus.eof, 0);
      chk("rst_i_out", bus.i_out, 0);
      chk("rst_q_out", bus.q_out, 0);
    end
    tick();
    reset = 1'b0;
  endtask

  function automatic int qpsk_i(input int n);
    return ((n >> 1) & 1) != 0 ? -A : A;
  endfunction

  function automatic int qpsk_q(input int n);
    return (n & 1) != 0 ? -A : A;
  endfunction

  initial begin
    vecs = '{
      '{1'b0, 4'h0,  A,   A}, '{1'b0, 4'h1,  A,  -A},
      '{1'b0, 4'h2, -A,   A}, '{1'b0, 4'h3, -A,  -A},
      '{1'b0, 4'hD,  A,  -A}, '{1'b0, 4'hE, -A,   A},
      '{1'b1, 4'h0, -U3, -U3}, '{1'b1, 4'h1, -U3, -U},
      '{1'b1, 4'h2, -U3,  U3}, '{1'b1, 4'h3, -U3,  U},
      '{1'b1, 4'h4, -U,  -U3}, '{1'b1, 4'h5, -U,  -U},
      '{1'b1, 4'h6, -U,   U3}, '{1'b1, 4'h7, -U,   U},
      '{1'b1, 4'h8,  U3, -U3}, '{1'b1, 4'h9,  U3, -U},
      '{1'b1, 4'hA,  U3,  U3}, '{1'b1, 4'hB,  U3,  U},
      '{1'b1, 4'hC,  U,  -U3}, '{1'b1, 4'hD,  U,  -U},
      '{1'b1, 4'hE,  U,   U3}, '{1'b1, 4'hF,  U,   U}
    };

    // Single-word mapping and two-cycle latency for every table entry.
    for (int i = 0; i < 22; i++) begin
      do_reset(vecs[i].mode, i == 0);
      bus.ready_in  = 1'b1;
      bus.valid_rom = 1'b1;
      bus.idata     = vecs[i].idata;
      @(negedge clk);
      chk($sformatf("v%0d_ready_first", i), bus.ready_out, 1);
      tick();
      bus.valid_rom = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_lat1_valid", i), bus.valid_out, 0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), bus.valid_out, 1);
      chk($sformatf("v%0d_i", i), bus.i_out, vecs[i].exp_i);
      chk($sformatf("v%0d_q", i), bus.q_out, vecs[i].exp_q);
      chk($sformatf("v%0d_sof", i), bus.sof, 1);
    end

    // mod_switch toggled without reset must not change the mapping.
    do_reset(1'b1, 1'b0);
    mod_switch    = 1'b0;
    bus.ready_in  = 1'b1;
    bus.valid_rom = 1'b1;
    bus.idata     = 4'hB;
    tick();
    bus.valid_rom = 1'b0;
    tick();
    @(negedge clk);
    chk("modeheld_i", bus.i_out, U3);
    chk("modeheld_q", bus.q_out, U);

    // Back-pressure with a source that honours ready_out one cycle late.
    begin
      bit prev_ready = 1'b1;
      int sent = 0;
      int sent_at_fall = -1;
      do_reset(1'b0, 1'b0);
      bus.ready_in = 1'b0;
      for (int c = 0; c < 8; c++) begin
        bus.valid_rom = prev_ready && (sent < 8);
        bus.idata     = 4'(sent);
        @(negedge clk);
        if (bus.valid_rom) sent++;
        if (!bus.ready_out && sent_at_fall < 0) sent_at_fall = sent;
        prev_ready = bus.ready_out;
        tick();
      end
      bus.valid_rom = 1'b0;
      @(negedge clk);
      chk("bp_sent", sent, 4);
      chk("bp_fall_point", sent_at_fall, 4);
      chk("bp_ready_low", bus.ready_out, 0);
      chk("bp_overflow", overflow, 0);
      chk("bp_head_stable_i", bus.i_out, A);
      chk("bp_sc_hold", bus.sc_idx, 0);
      tick();
      bus.ready_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("bp_drain%0d_valid", k), bus.valid_out, 1);
        chk($sformatf("bp_drain%0d_i", k), bus.i_out, qpsk_i(k));
        chk($sformatf("bp_drain%0d_q", k), bus.q_out, qpsk_q(k));
        chk($sformatf("bp_drain%0d_sc", k), bus.sc_idx, k);
        tick();
      end
      @(negedge clk);
      chk("bp_empty", bus.valid_out, 0);
    end

    // Overflow: continuous valid_rom into a stalled 16-QAM mapper.
    do_reset(1'b1, 1'b0);
    bus.ready_in = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.valid_rom = 1'b1;
      bus.idata     = 4'(c);
      @(negedge clk);
      chk($sformatf("ovf_c%0d", c), overflow, (c >= 5) ? 1 : 0);
      tick();
    end
    bus.valid_rom = 1'b0;
    tick();
    bus.ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ovf_drain%0d_valid", k), bus.valid_out, 1);
      chk($sformatf("ovf_drain%0d_i", k), bus.i_out, vecs[6+k].exp_i);
      chk($sformatf("ovf_drain%0d_q", k), bus.q_out, vecs[6+k].exp_q);
      tick();
    end
    @(negedge clk);
    chk("ovf_empty", bus.valid_out, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-stream with three points buffered and sc_idx nonzero.
    do_reset(1'b0, 1'b0);
    bus.ready_in  = 1'b1;
    bus.valid_rom = 1'b1;
    bus.idata     = 4'h0;
    tick();
    bus.valid_rom = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rms_sc_before", bus.sc_idx, 1);
    tick();
    bus.ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.valid_rom = 1'b1;
      bus.idata     = 4'(k + 1);
      tick();
    end
    bus.valid_rom = 1'b0;
    tick();
    @(negedge clk);
    chk("rms_buffered", bus.valid_out, 1);
    tick();
    reset         = 1'b1;
    bus.valid_rom = 1'b1;
    tick();
    reset         = 1'b0;
    bus.valid_rom = 1'b0;
    @(negedge clk);
    chk("rms_valid", bus.valid_out, 0);
    chk("rms_sc", bus.sc_idx, 0);
    chk("rms_ready", bus.ready_out, 1);
    chk("rms_overflow", overflow, 0);
    bus.ready_in  = 1'b1;
    bus.valid_rom = 1'b1;
    bus.idata     = 4'h3;
    tick();
    bus.valid_rom = 1'b0;
    @(negedge clk);
    chk("rms_flushed", bus.valid_out, 0);
    tick();
    @(negedge clk);
    chk("rms_restart_valid", bus.valid_out, 1);
    chk("rms_restart_sof", bus.sof, 1);
    chk("rms_restart_i", bus.i_out, -A);

    // Framing over 130 points with random downstream stalls.
    begin
      bit prev_ready = 1'b1;
      int sent = 0;
      int got = 0;
      do_reset(1'b0, 1'b0);
      for (int cyc = 0; cyc < 3000 && got < 130; cyc++) begin
        bus.ready_in  = ($urandom_range(0, 3) != 0);
        bus.valid_rom = prev_ready && (sent < 130);
        bus.idata     = 4'(sent);
        @(negedge clk);
        if (bus.valid_rom) sent++;
        prev_ready = bus.ready_out;
        if (bus.valid_out && bus.ready_in) begin
          chk($sformatf("frm%0d_sc", got), bus.sc_idx, got % 64);
          chk($sformatf("frm%0d_sof", got), bus.sof, (got % 64 == 0) ? 1 : 0);
          chk($sformatf("frm%0d_eof", got), bus.eof, (got % 64 == 63) ? 1 : 0);
          chk($sformatf("frm%0d_i", got), bus.i_out, qpsk_i(got));
          chk($sformatf("frm%0d_q", got), bus.q_out, qpsk_q(got));
          got++;
        end
        tick();
      end
      chk("frm_count", got, 130);
      chk("frm_overflow", overflow, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
